// File: rtl/pio_input_debouncer_if.sv
// Signal bundle between the raw board pins / PIO in_port and pio_input_debouncer.
// master = pin/PIO side driving enable and raw_in; slave = the debouncer.
interface pio_input_debouncer_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] debounced_out;
    logic [WIDTH-1:0] rise_pulse;
    logic [WIDTH-1:0] fall_pulse;

    modport master (
        output enable,
        output raw_in,
        input  debounced_out,
        input  rise_pulse,
        input  fall_pulse
    );

    modport slave (
        input  enable,
        input  raw_in,
        output debounced_out,
        output rise_pulse,
        output fall_pulse
    );
endinterface

// File: rtl/pio_input_debouncer.sv
// Per-bit inversion, 2-flop synchroniser and tick-based stability filter for raw board inputs.
// Define PIO_DEBOUNCE_EVENT_EN to build the registered rise/fall edge strobes; otherwise they read 0.
module pio_input_debouncer #(
    parameter int               WIDTH        = 8,
    parameter int               TICK_DIV     = 50000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] INVERT_MASK  = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pio_input_debouncer_if.slave bus
);

    localparam int               PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [7:0]       CNT_LAST = 8'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] sync1_r;
    logic [WIDTH-1:0] sync2_r;
    logic [WIDTH-1:0] deb_r;
    logic [WIDTH-1:0] deb_next_s;
    logic [PRE_W-1:0] pre_r;
    logic             tick_s;
    logic [7:0]       cnt_r      [WIDTH];
    logic [7:0]       cnt_next_s [WIDTH];

    assign in_s   = bus.raw_in ^ INVERT_MASK;
    assign tick_s = (pre_r == PRE_LAST);

    // Two-stage synchroniser bringing the pins into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= RESET_VALUE;
            sync2_r <= RESET_VALUE;
        end else begin
            sync1_r <= in_s;
            sync2_r <= sync1_r;
        end
    end

    // Free-running prescaler; deliberately ignores enable so tick phase is stable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_r <= PRE_ZERO;
        end else if (pre_r == PRE_LAST) begin
            pre_r <= PRE_ZERO;
        end else begin
            pre_r <= pre_r + PRE_ONE;
        end
    end

    // Per-bit stability filter next state; disable clears counts, a matching level restarts them.
    always_comb begin
        deb_next_s = deb_r;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_next_s[i] = cnt_r[i];
            if (!bus.enable) begin
                cnt_next_s[i] = 8'd0;
            end else if (sync2_r[i] == deb_r[i]) begin
                cnt_next_s[i] = 8'd0;
            end else if (tick_s) begin
                // >= keeps the counter bounded even if it were ever corrupted past the limit
                if (cnt_r[i] >= CNT_LAST) begin
                    deb_next_s[i] = sync2_r[i];
                    cnt_next_s[i] = 8'd0;
                end else begin
                    cnt_next_s[i] = cnt_r[i] + 8'd1;
                end
            end else begin
                cnt_next_s[i] = cnt_r[i];
            end
        end
    end

    // Filter state registers: debounced level and per-bit stability counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_r <= RESET_VALUE;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= 8'd0;
            end
        end else begin
            deb_r <= deb_next_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    assign bus.debounced_out = deb_r;

`ifdef PIO_DEBOUNCE_EVENT_EN
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;

    // Edge strobes registered on the same edge that updates deb_r, so they align with the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
        end else begin
            rise_r <= deb_next_s & ~deb_r;
            fall_r <= ~deb_next_s & deb_r;
        end
    end

    assign bus.rise_pulse = rise_r;
    assign bus.fall_pulse = fall_r;
`else
    assign bus.rise_pulse = {WIDTH{1'b0}};
    assign bus.fall_pulse = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pio_input_debouncer.sv
// Self-checking bench for pio_input_debouncer (TICK_DIV=4, STABLE_TICKS=3, INVERT_MASK=8'h0F).
// Expected level changes go into a scoreboard queue when stimulus is driven and are popped when the DUT changes.
module tb_pio_input_debouncer;

    localparam int W = 8;
`ifdef PIO_DEBOUNCE_EVENT_EN
    localparam bit EV_EN = 1'b1;
`else
    localparam bit EV_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] raw;
        logic       en;
        int         hold;
        logic [7:0] chg_mask;
        logic [7:0] exp_out;
    } step_t;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] val;
        int         lo;
        int         hi;
    } sb_t;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    int         cyc      = 0;
    int         n_cmp    = 0;
    int         n_err    = 0;
    sb_t        sb_q[$];
    logic [7:0] prev_deb = 8'h00;
    logic [7:0] chg_m;
    sb_t        mon_e;

    pio_input_debouncer_if #(.WIDTH(W)) bus ();

    pio_input_debouncer #(
        .WIDTH       (W),
        .TICK_DIV    (4),
        .STABLE_TICKS(3),
        .INVERT_MASK (8'h0F),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [7:0] mask, input logic [7:0] val, input int lo, input int hi);
        sb_t e;
        e.mask = mask;
        e.val  = val & mask;
        e.lo   = lo;
        e.hi   = hi;
        sb_q.push_back(e);
    endtask

    // Monitor: pulse alignment every cycle, and every level change matched against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            chg_m = bus.debounced_out ^ prev_deb;
            check8("rise_pulse", bus.rise_pulse, EV_EN ? (bus.debounced_out & ~prev_deb) : 8'h00);
            check8("fall_pulse", bus.fall_pulse, EV_EN ? (~bus.debounced_out & prev_deb) : 8'h00);
            if (chg_m != 8'h00) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_change: got %h, expected no change (cycle %0d)",
                             bus.debounced_out, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check8("chg_mask", chg_m, mon_e.mask);
                    check8("chg_value", bus.debounced_out & mon_e.mask, mon_e.val);
                    n_cmp++;
                    if (cyc < mon_e.lo || cyc > mon_e.hi) begin
                        n_err++;
                        $display("FAIL chg_latency: got edge %0d, expected %0d..%0d", cyc, mon_e.lo, mon_e.hi);
                    end
                end
            end
        end
        prev_deb = bus.debounced_out;
    end

    task automatic run_step(input int k, input step_t s);
        int t0;
        bus.raw_in = s.raw;
        bus.enable = s.en;
        t0 = cyc;
        if (s.chg_mask != 8'h00) push_exp(s.chg_mask, s.exp_out, t0 + 11, t0 + 14);
        repeat (s.hold) @(negedge clk);
        check8($sformatf("step%0d_out", k), bus.debounced_out, s.exp_out);
    endtask

    step_t steps[7];

    initial begin
        int t0;
        int t1;
        int r;

        steps[0] = '{8'h0F, 1'b1, 50, 8'h00, 8'h00};  // idle active-low keys
        steps[1] = '{8'h1F, 1'b1, 20, 8'h10, 8'h10};  // bit 4 high
        steps[2] = '{8'h0F, 1'b1, 20, 8'h10, 8'h00};  // bit 4 released
        steps[3] = '{8'h8E, 1'b1, 20, 8'h81, 8'h81};  // bit 0 pressed + bit 7 high together
        steps[4] = '{8'h0F, 1'b1, 20, 8'h81, 8'h00};
        steps[5] = '{8'h6D, 1'b1, 20, 8'h62, 8'h62};  // bits 1,5,6 together
        steps[6] = '{8'h0F, 1'b1, 20, 8'h62, 8'h00};

        bus.raw_in = 8'h0F;
        bus.enable = 1'b1;
        repeat (3) @(negedge clk);
        check8("reset_out", bus.debounced_out, 8'h00);
        check8("reset_rise", bus.rise_pulse, 8'h00);
        check8("reset_fall", bus.fall_pulse, 8'h00);
        reset_n = 1'b1;

        for (int k = 0; k < 7; k++) begin
            run_step(k, steps[k]);
        end

        // Bouncing bit 5: mismatches never outlast a tick interval, so no change is expected.
        for (int n = 0; n < 13; n++) begin
            bus.raw_in = bus.raw_in ^ 8'h20;
            repeat (3) @(negedge clk);
        end
        bus.raw_in = 8'h0F;
        repeat (20) @(negedge clk);
        check8("bounce_out", bus.debounced_out, 8'h00);

        // Disable while bit 2 is mid-count; acceptance needs a fresh count afterwards.
        bus.raw_in = 8'h0B;
        repeat (7) @(negedge clk);
        bus.enable = 1'b0;
        repeat (20) @(negedge clk);
        check8("disable_hold", bus.debounced_out, 8'h00);
        bus.enable = 1'b1;
        t1 = cyc;
        push_exp(8'h04, 8'h04, t1 + 9, t1 + 12);
        repeat (20) @(negedge clk);
        check8("reenable_out", bus.debounced_out, 8'h04);
        run_step(7, '{8'h0F, 1'b1, 20, 8'h04, 8'h00});

        // Reset while bit 3 has two ticks counted; prescaler restarts so acceptance lands exactly at r+12.
        bus.raw_in = 8'h07;
        t0 = cyc;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check8("midreset_out", bus.debounced_out, 8'h00);
        check8("midreset_rise", bus.rise_pulse, 8'h00);
        check8("midreset_fall", bus.fall_pulse, 8'h00);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        r = cyc;
        push_exp(8'h08, 8'h08, r + 12, r + 12);
        repeat (20) @(negedge clk);
        check8("postreset_out", bus.debounced_out, 8'h08);
        run_step(8, '{8'h0F, 1'b1, 20, 8'h08, 8'h00});

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending changes, expected 0 (first started at %0d)",
                     sb_q.size(), t0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
